// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_sequencer
// Brief    : Sequences one fully-connected layer: config load, activation/weight
//            fetch, MAC framing and per-neuron result write. Optional
//            SEQ_STALL_CNT_EN macro adds a saturating FIFO-stall counter.
// Revision : 1.0
// ============================================================================
module layer_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        busrdwr,
   input  logic [15:0] data_bus,
   input  logic        dval,
   input  logic        fifo_empty,
   output logic        fifo_rd_req,
   output logic        bram_rd,
   output logic [15:0] bram_addr,
   output logic        mac_en,
   output logic        mac_first,
   output logic        mac_last,
   output logic        out_wr,
   output logic [15:0] out_addr,
   output logic        busy,
   output logic        layer_done,
   output logic [15:0] stall_cnt
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_CFG   = 3'd1;
   localparam logic [2:0] c_ARMED = 3'd2;
   localparam logic [2:0] c_RUN   = 3'd3;
   localparam logic [2:0] c_DRAIN = 3'd4;
   localparam logic [2:0] c_WRITE = 3'd5;
   localparam logic [2:0] c_DONE  = 3'd6;

   logic [2:0]  r_state;
   logic [2:0]  r_widx;
   logic [15:0] r_wbase;
   logic [15:0] r_obase;
   logic [15:0] r_n_in;
   logic [15:0] r_n_out;
   logic [15:0] r_in_idx;
   logic [15:0] r_out_idx;
   logic [15:0] r_wptr;
   logic        r_mac_en;
   logic        r_mac_first;
   logic        r_mac_last;

   logic w_issue;
   logic w_last_in;
   logic w_last_out;
   logic w_start;

   assign w_issue    = (r_state == c_RUN) && !fifo_empty;
   assign w_last_in  = (r_in_idx == r_n_in - 16'd1);
   assign w_last_out = (r_out_idx == r_n_out - 16'd1);
   assign w_start    = (r_state == c_ARMED) && !busrdwr && dval;

   assign fifo_rd_req = w_issue;
   assign bram_rd     = w_issue;
   assign bram_addr   = w_issue ? r_wptr : 16'd0;
   assign mac_en      = r_mac_en;
   assign mac_first   = r_mac_first;
   assign mac_last    = r_mac_last;
   assign out_wr      = (r_state == c_WRITE);
   assign out_addr    = out_wr ? (r_obase + r_out_idx) : 16'd0;
   assign layer_done  = (r_state == c_DONE);
   assign busy        = (r_state == c_RUN) || (r_state == c_DRAIN) ||
                        (r_state == c_WRITE) || (r_state == c_DONE);

   // Word 1 (input base) is accepted but not stored: activations arrive in
   // order through the FIFO, so no input address is ever generated.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= c_IDLE;
         r_widx    <= 3'd0;
         r_wbase   <= 16'd0;
         r_obase   <= 16'd0;
         r_n_in    <= 16'd0;
         r_n_out   <= 16'd0;
         r_in_idx  <= 16'd0;
         r_out_idx <= 16'd0;
         r_wptr    <= 16'd0;
      end else begin
         case (r_state)
            c_IDLE, c_ARMED: begin
               if (busrdwr) begin
                  r_wbase <= data_bus;
                  r_widx  <= 3'd1;
                  r_state <= c_CFG;
               end else if (w_start) begin
                  r_in_idx  <= 16'd0;
                  r_out_idx <= 16'd0;
                  r_wptr    <= r_wbase;
                  r_state   <= ((r_n_in == 16'd0) || (r_n_out == 16'd0)) ? c_DONE : c_RUN;
               end
            end
            c_CFG: begin
               if (busrdwr) begin
                  r_widx <= r_widx + 3'd1;
                  case (r_widx)
                     3'd2:    r_obase <= data_bus;
                     3'd3:    r_n_in  <= data_bus;
                     3'd4: begin
                        r_n_out <= data_bus;
                        r_state <= c_ARMED;
                     end
                     default: ;
                  endcase
               end
            end
            c_RUN: begin
               if (w_issue) begin
                  r_wptr <= r_wptr + 16'd1;
                  if (w_last_in) r_state  <= c_DRAIN;
                  else           r_in_idx <= r_in_idx + 16'd1;
               end
            end
            c_DRAIN: r_state <= c_WRITE;
            c_WRITE: begin
               if (w_last_out) begin
                  r_state <= c_DONE;
               end else begin
                  r_out_idx <= r_out_idx + 16'd1;
                  r_in_idx  <= 16'd0;
                  r_state   <= c_RUN;
               end
            end
            c_DONE:  r_state <= c_ARMED;
            default: r_state <= c_IDLE;
         endcase
      end
   end

   // MAC controls trail the read strobe by one cycle, matching weight/data latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mac_en    <= 1'b0;
         r_mac_first <= 1'b0;
         r_mac_last  <= 1'b0;
      end else begin
         r_mac_en    <= w_issue;
         r_mac_first <= w_issue && (r_in_idx == 16'd0);
         r_mac_last  <= w_issue && w_last_in;
      end
   end

`ifdef SEQ_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= 16'd0;
      end else if (w_start) begin
         r_stall_cnt <= 16'd0;
      end else if ((r_state == c_RUN) && fifo_empty && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
